// File: rtl/vc_vr_pkg.sv
// vc_vr_pkg: shared credit-count sizing for the valid/ready <-> valid/credit bridges
package vc_vr_pkg;
  function automatic int cnt_w(input int credit_num);
    return $clog2(credit_num + 1);
  endfunction
  localparam int DEF_CREDIT_NUM = 2;
  typedef logic [cnt_w(DEF_CREDIT_NUM)-1:0] credit_cnt_t;
endpackage

// File: rtl/vc_credit_counter.sv
// vc_credit_counter: up/down credit counter saturating at MAX; o_ovf flags a dropped credit
// when VR_VC_CREDIT_CHECK_EN is defined, otherwise o_ovf is tied low
module vc_credit_counter
  import vc_vr_pkg::*;
#(
  parameter int MAX = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_inc,
  input  logic                  i_dec,
  output logic [cnt_w(MAX)-1:0] o_cnt,
  output logic                  o_nonzero,
  output logic                  o_ovf
);
  localparam int W = cnt_w(MAX);
  logic [W-1:0] r_cnt;
  logic         w_full;
  assign w_full    = r_cnt == W'(MAX);
  assign o_nonzero = r_cnt != '0;
  assign o_cnt     = r_cnt;
  always_ff @(posedge clk)
    if (rst) r_cnt <= W'(MAX);
    else     r_cnt <= (i_inc && !i_dec && !w_full)    ? r_cnt + 1'b1 :
                      (i_dec && !i_inc && o_nonzero) ? r_cnt - 1'b1 : r_cnt;
`ifdef VR_VC_CREDIT_CHECK_EN
  assign o_ovf = i_inc && !i_dec && w_full;
`else
  assign o_ovf = 1'b0;
`endif
endmodule

// File: rtl/vr_vc_converter.sv
// vr_vc_converter: valid/ready upstream to valid/credit downstream, one registered flit per handshake
// VR_VC_CREDIT_CHECK_EN enables the sticky credit-overflow error on err_o
module vr_vc_converter
  import vc_vr_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CREDIT_NUM = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DATA_WIDTH-1:0]        s_data_i,
  input  logic                         s_valid_i,
  output logic                         s_ready_o,
  output logic [DATA_WIDTH-1:0]        m_data_o,
  output logic                         m_valid_o,
  input  logic                         m_credit_i,
  output logic [cnt_w(CREDIT_NUM)-1:0] credit_cnt_o,
  output logic                         err_o
);
  logic                  w_nonzero;
  logic                  w_send;
  logic                  w_ovf;
  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_data;
  assign s_ready_o = w_nonzero;
  assign w_send    = s_valid_i && w_nonzero;
  assign m_valid_o = r_valid;
  assign m_data_o  = r_data;
  vc_credit_counter #(.MAX(CREDIT_NUM)) u_cnt (
    .clk       (clk),
    .rst       (rst),
    .i_inc     (m_credit_i),
    .i_dec     (w_send),
    .o_cnt     (credit_cnt_o),
    .o_nonzero (w_nonzero),
    .o_ovf     (w_ovf)
  );
  always_ff @(posedge clk)
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      r_valid <= w_send;
      r_data  <= w_send ? s_data_i : r_data;
    end
`ifdef VR_VC_CREDIT_CHECK_EN
  logic r_err;
  assign err_o = r_err;
  always_ff @(posedge clk)
    if (rst) r_err <= 1'b0;
    else begin
      if (w_ovf) r_err <= 1'b1;
      assert (!(w_send && !w_nonzero)) else r_err <= 1'b1;
    end
`else
  assign err_o = w_ovf;
`endif
endmodule

// File: tb/tb_vr_vc_converter.sv
// tb_vr_vc_converter: directed scenarios then random traffic against a credit-accounting model
module tb_vr_vc_converter;
  localparam int N = 2;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] s_data_i = '0;
  logic       s_valid_i = 1'b0;
  logic       s_ready_o;
  logic [7:0] m_data_o;
  logic       m_valid_o;
  logic       m_credit_i = 1'b0;
  logic [1:0] credit_cnt_o;
  logic       err_o;
  int checks = 0;
  int failures = 0;
  int m_cnt = N;
  bit m_valid = 0;
  bit m_err = 0;
  logic [7:0] m_data = '0;
  always #5 clk = ~clk;
  vr_vc_converter #(.DATA_WIDTH(8), .CREDIT_NUM(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .s_data_i     (s_data_i),
    .s_valid_i    (s_valid_i),
    .s_ready_o    (s_ready_o),
    .m_data_o     (m_data_o),
    .m_valid_o    (m_valid_o),
    .m_credit_i   (m_credit_i),
    .credit_cnt_o (credit_cnt_o),
    .err_o        (err_o)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask
  task automatic cycle(input bit v, input logic [7:0] d, input bit c, input bit r);
    bit send, ovf;
    s_valid_i = v; s_data_i = d; m_credit_i = c; rst = r;
    if (r) begin
      m_cnt = N; m_valid = 0; m_data = '0; m_err = 0;
    end else begin
      send = v && m_cnt > 0;
      ovf  = c && !send && m_cnt == N;
      m_cnt = m_cnt - int'(send) + int'(c);
      if (m_cnt > N) m_cnt = N;
      m_valid = send;
      if (send) m_data = d;
`ifdef VR_VC_CREDIT_CHECK_EN
      if (ovf) m_err = 1;
`else
      if (ovf) m_err = 0;
`endif
    end
    @(posedge clk); #1;
    chk("valid", m_valid_o, m_valid);
    chk("data",  m_data_o, m_data);
    chk("cnt",   credit_cnt_o, m_cnt);
    chk("ready", s_ready_o, m_cnt != 0);
    chk("err",   err_o, m_err);
  endtask
  initial begin
    cycle(0, 8'h00, 0, 1);
    cycle(0, 8'h00, 0, 1);
    cycle(0, 8'h00, 0, 0);
    cycle(1, 8'hAA, 0, 0);
    cycle(1, 8'hBB, 0, 0);
    cycle(1, 8'hCC, 0, 0);
    cycle(1, 8'hCC, 1, 0);
    cycle(1, 8'hCC, 0, 0);
    cycle(0, 8'h00, 0, 0);
    cycle(0, 8'h00, 1, 0);
    cycle(1, 8'hDD, 1, 0);
    cycle(0, 8'h00, 1, 0);
    cycle(0, 8'h00, 1, 0);
    cycle(0, 8'h00, 0, 0);
    cycle(1, 8'h11, 0, 0);
    cycle(1, 8'h22, 0, 0);
    cycle(0, 8'h00, 0, 1);
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(3) != 0, 8'($urandom), $urandom_range(2) == 0, $urandom_range(99) == 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
